// File: rtl/dram_cmd_decoder_pipe.sv
// dram_cmd_decoder_pipe: registered DRAM command decoder with per-bank
// open/row tracking and protocol-violation flagging. A single output
// register sits behind a valid/ready handshake on each side.
// Optional build macro: DRAM_CMD_DECODER_STATS_EN adds saturating
// forwarded-beat and error-beat counters (stat_cmds / stat_errs).
module dram_cmd_decoder_pipe #(
  parameter int ADDR_W = 32,
  parameter int ROW_W  = 16,
  parameter int COL_W  = 10,
  parameter int BANK_W = 3,
  // Derived from BANK_W; not meant to be overridden.
  localparam int NUM_BANKS = 2**BANK_W
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_cs,
  input  logic                 in_ras,
  input  logic                 in_cas,
  input  logic                 in_we,
  input  logic [ADDR_W-1:0]    in_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_cmd,
  output logic [ROW_W-1:0]     out_row,
  output logic [COL_W-1:0]     out_col,
  output logic [BANK_W-1:0]    out_bank,
  output logic [2:0]           out_err,
  output logic [NUM_BANKS-1:0] bank_open
`ifdef DRAM_CMD_DECODER_STATS_EN
  ,
  output logic [31:0]          stat_cmds,
  output logic [15:0]          stat_errs
`endif
);

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ACT = 4'd1;
  localparam logic [3:0] CMD_RD  = 4'd2;
  localparam logic [3:0] CMD_WR  = 4'd3;
  localparam logic [3:0] CMD_PRE = 4'd4;
  localparam logic [3:0] CMD_REF = 4'd5;

  localparam logic [2:0] ERR_OK          = 3'd0;
  localparam logic [2:0] ERR_RDWR_CLOSED = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN    = 3'd2;
  localparam logic [2:0] ERR_ROW_MISS    = 3'd3;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd4;

  localparam int LSB_W = ADDR_W - ROW_W - COL_W - BANK_W;

  // Address fields, row at the top, then column, then bank.
  logic [ROW_W-1:0]  in_row;
  logic [COL_W-1:0]  in_col;
  logic [BANK_W-1:0] in_bank;
  assign in_row  = in_addr[ADDR_W-1 -: ROW_W];
  assign in_col  = in_addr[ADDR_W-ROW_W-1 -: COL_W];
  assign in_bank = in_addr[ADDR_W-ROW_W-COL_W-1 -: BANK_W];

  // Byte-offset bits below the bank field carry no command information.
  generate
    if (LSB_W > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^in_addr[LSB_W-1:0];
    end
  endgenerate

  // Tracker and output register state.
  logic [NUM_BANKS-1:0] open_reg;
  logic [ROW_W-1:0]     open_row_reg [NUM_BANKS];
  logic                 out_valid_reg;
  logic [3:0]           out_cmd_reg;
  logic [ROW_W-1:0]     out_row_reg;
  logic [COL_W-1:0]     out_col_reg;
  logic [BANK_W-1:0]    out_bank_reg;
  logic [2:0]           out_err_reg;

  logic [3:0] dec_cmd;
  logic [2:0] err_next;
  logic       legal;
  logic       accept;
  logic       load;
  logic       track_upd;

  // Command decode from {we,cas,ras}.
  always_comb begin
    dec_cmd = CMD_NOP;
    case ({in_we, in_cas, in_ras})
      3'b000:  dec_cmd = CMD_REF;
      3'b001:  dec_cmd = CMD_WR;
      3'b010:  dec_cmd = CMD_RD;
      3'b011:  dec_cmd = CMD_ACT;
      3'b100:  dec_cmd = CMD_PRE;
      default: dec_cmd = CMD_NOP;
    endcase
  end

  assign legal = in_cs & ~(in_ras & in_cas & in_we) & (dec_cmd != CMD_NOP);

  // Held during reset so upstream never sees a stall while we are cleared.
  assign in_ready  = ~sys_rst_n | ~out_valid_reg | out_ready;
  assign accept    = in_valid & in_ready;
  assign load      = accept & legal;
  assign track_upd = load & (err_next == ERR_OK);

  // Protocol check against the tracker state before this beat's update.
  always_comb begin
    err_next = ERR_OK;
    case (dec_cmd)
      CMD_ACT: if (open_reg[in_bank]) err_next = ERR_ACT_OPEN;
      CMD_RD, CMD_WR: begin
        if (!open_reg[in_bank])                  err_next = ERR_RDWR_CLOSED;
        else if (open_row_reg[in_bank] != in_row) err_next = ERR_ROW_MISS;
      end
      CMD_REF: if (|open_reg) err_next = ERR_REF_OPEN;
      default: err_next = ERR_OK;
    endcase
  end

  // Output register: load on legal accepted beat, clear on drain, else hold.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      out_valid_reg <= 1'b0;
      out_cmd_reg   <= '0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
      out_bank_reg  <= '0;
      out_err_reg   <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_cmd_reg   <= dec_cmd;
      out_row_reg   <= in_row;
      out_col_reg   <= in_col;
      out_bank_reg  <= in_bank;
      out_err_reg   <= err_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Per-bank tracker: ACTIVATE opens with its row, PRECHARGE closes.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
          open_reg[gi]     <= 1'b0;
          open_row_reg[gi] <= '0;
        end else if (track_upd && (in_bank == BANK_W'(gi))) begin
          if (dec_cmd == CMD_ACT) begin
            open_reg[gi]     <= 1'b1;
            open_row_reg[gi] <= in_row;
          end else if (dec_cmd == CMD_PRE) begin
            open_reg[gi]     <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_cmd   = out_cmd_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;
  assign out_bank  = out_bank_reg;
  assign out_err   = out_err_reg;
  assign bank_open = open_reg;

`ifdef DRAM_CMD_DECODER_STATS_EN
  logic [31:0] stat_cmds_reg;
  logic [15:0] stat_errs_reg;

  // Saturating counters of forwarded beats and forwarded error beats.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      stat_cmds_reg <= '0;
      stat_errs_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      if (stat_cmds_reg != '1) stat_cmds_reg <= stat_cmds_reg + 32'd1;
      if ((out_err_reg != ERR_OK) && (stat_errs_reg != '1))
        stat_errs_reg <= stat_errs_reg + 16'd1;
    end
  end

  assign stat_cmds = stat_cmds_reg;
  assign stat_errs = stat_errs_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dram_cmd_decoder_pipe.sv
// Bench for dram_cmd_decoder_pipe: directed vector table from the test plan,
// hand sequences for backpressure and reset-while-busy, then randomized
// traffic checked against a transaction-level model of banks and the
// single-entry output slot.
module tb_dram_cmd_decoder_pipe;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_cs = 1'b0, in_ras = 1'b0, in_cas = 1'b0, in_we = 1'b0;
  logic [31:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_cmd;
  logic [15:0] out_row;
  logic [9:0]  out_col;
  logic [2:0]  out_bank;
  logic [2:0]  out_err;
  logic [7:0]  bank_open;

  dram_cmd_decoder_pipe dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cs(in_cs), .in_ras(in_ras), .in_cas(in_cas), .in_we(in_we),
    .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cmd(out_cmd), .out_row(out_row), .out_col(out_col),
    .out_bank(out_bank), .out_err(out_err), .bank_open(bank_open)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bank table plus the single output slot.
  bit          m_open [8];
  int          m_row  [8];
  bit          m_ov;
  int          m_cmd, m_brow, m_col, m_bank, m_err;
  int          cmd_of [8];

  function automatic int model_open_mask();
    int m = 0;
    for (int i = 0; i < 8; i++) if (m_open[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
    m_ov = 0;
  endtask

  // One cycle: drive a beat at the negedge, predict, clock, compare.
  task automatic step(input bit v, input bit cs, input bit we, input bit cas,
                      input bit ras, input logic [31:0] addr, input bit ordy);
    int  cmd, row, col, bank, err, any;
    bit  acc, lgl;
    in_valid = v; in_cs = cs; in_we = we; in_cas = cas; in_ras = ras;
    in_addr = addr; out_ready = ordy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || ordy)});
    acc = v && (!m_ov || ordy);
    if (m_ov && ordy) m_ov = 0;
    cmd  = cmd_of[{we, cas, ras}];
    row  = addr >> 16;
    col  = (addr >> 6) & 32'h3ff;
    bank = (addr >> 3) & 7;
    lgl  = cs && !(we && cas && ras) && (cmd != 0);
    if (acc && lgl) begin
      any = model_open_mask();
      err = 0;
      if (cmd == 1 && m_open[bank]) err = 2;
      else if ((cmd == 2 || cmd == 3) && !m_open[bank]) err = 1;
      else if ((cmd == 2 || cmd == 3) && m_row[bank] != row) err = 3;
      else if (cmd == 5 && any != 0) err = 4;
      if (err == 0 && cmd == 1) begin m_open[bank] = 1; m_row[bank] = row; end
      if (err == 0 && cmd == 4) m_open[bank] = 0;
      m_ov = 1; m_cmd = cmd; m_brow = row; m_col = col; m_bank = bank; m_err = err;
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk("out_cmd",  {28'd0, out_cmd},  m_cmd);
      chk("out_row",  {16'd0, out_row},  m_brow);
      chk("out_col",  {22'd0, out_col},  m_col);
      chk("out_bank", {29'd0, out_bank}, m_bank);
      chk("out_err",  {29'd0, out_err},  m_err);
    end
    chk("bank_open", {24'd0, bank_open}, model_open_mask());
  endtask

  typedef struct {
    bit          cs, we, cas, ras;
    logic [31:0] addr;
    bit          exp_valid;
    logic [3:0]  exp_cmd;
    logic [2:0]  exp_err;
    logic [15:0] exp_row;
    logic [2:0]  exp_bank;
    logic [7:0]  exp_open;
  } vec_t;

  vec_t tbl [11];

  initial begin
    cmd_of = '{5, 3, 2, 1, 4, 0, 0, 0};
    model_reset();
    // cs we cas ras addr | valid cmd err row bank open
    tbl[0]  = '{1, 0, 1, 1, 32'h1234_0010, 1, 1, 0, 16'h1234, 2, 8'h04}; // ACT b2
    tbl[1]  = '{1, 0, 1, 0, 32'h1234_0010, 1, 2, 0, 16'h1234, 2, 8'h04}; // READ hit
    tbl[2]  = '{1, 0, 1, 0, 32'h5678_0010, 1, 2, 3, 16'h5678, 2, 8'h04}; // READ miss
    tbl[3]  = '{1, 0, 0, 1, 32'h0000_0028, 1, 3, 1, 16'h0000, 5, 8'h04}; // WRITE closed
    tbl[4]  = '{1, 0, 1, 1, 32'h1234_0010, 1, 1, 2, 16'h1234, 2, 8'h04}; // ACT open
    tbl[5]  = '{1, 0, 0, 0, 32'h0000_0000, 1, 5, 4, 16'h0000, 0, 8'h04}; // REF open
    tbl[6]  = '{1, 1, 0, 0, 32'h0000_0010, 1, 4, 0, 16'h0000, 2, 8'h00}; // PRE b2
    tbl[7]  = '{1, 0, 0, 0, 32'h0000_0000, 1, 5, 0, 16'h0000, 0, 8'h00}; // REF ok
    tbl[8]  = '{0, 0, 1, 1, 32'h1234_0010, 0, 0, 0, 16'h0000, 0, 8'h00}; // cs=0
    tbl[9]  = '{1, 1, 1, 1, 32'h1234_0010, 0, 0, 0, 16'h0000, 0, 8'h00}; // 111
    tbl[10] = '{1, 1, 0, 1, 32'h1234_0010, 0, 0, 0, 16'h0000, 0, 8'h00}; // 101

    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_cmd", {28'd0, out_cmd}, 0);
    chk("rst_out_row", {16'd0, out_row}, 0);
    chk("rst_out_err", {29'd0, out_err}, 0);
    chk("rst_bank_open", {24'd0, bank_open}, 0);
    sys_rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      step(1, tbl[i].cs, tbl[i].we, tbl[i].cas, tbl[i].ras, tbl[i].addr, 1);
      $display("[TB] vec %0d: valid=%0d cmd=%0d err=%0d row=%0h bank=%0d open=%0h",
               i, out_valid, out_cmd, out_err, out_row, out_bank, bank_open);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_cmd", i), {28'd0, out_cmd}, {28'd0, tbl[i].exp_cmd});
        chk($sformatf("vec%0d_err", i), {29'd0, out_err}, {29'd0, tbl[i].exp_err});
        chk($sformatf("vec%0d_row", i), {16'd0, out_row}, {16'd0, tbl[i].exp_row});
        chk($sformatf("vec%0d_bank", i), {29'd0, out_bank}, {29'd0, tbl[i].exp_bank});
      end
      chk($sformatf("vec%0d_open", i), {24'd0, bank_open}, {24'd0, tbl[i].exp_open});
    end

    // Backpressure: beat A held while out_ready=0, beat B stalls, then drains.
    step(1, 1, 0, 1, 1, 32'h0AAA_0008, 0);   // ACT b1 accepted, held
    step(1, 1, 0, 1, 0, 32'h0AAA_0048, 0);   // READ b1 stalled
    step(1, 1, 0, 1, 0, 32'h0AAA_0048, 0);   // still stalled
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_held_cmd", {28'd0, out_cmd}, 1);
    step(1, 1, 0, 1, 0, 32'h0AAA_0048, 1);   // A drains, B loads
    chk("bp_b_cmd", {28'd0, out_cmd}, 2);
    chk("bp_b_col", {22'd0, out_col}, 1);
    step(1, 1, 1, 0, 0, 32'h0000_0008, 1);   // B drains, PRE b1 loads
    chk("bp_c_cmd", {28'd0, out_cmd}, 4);
    step(0, 0, 0, 0, 0, 32'h0, 1);           // C drains, nothing new
    $display("[TB] backpressure: out_valid=%0d bank_open=%0h", out_valid, bank_open);

    // Reset while a beat is held and a bank is open.
    step(1, 1, 0, 1, 1, 32'h0BBB_0018, 0);   // ACT b3 held
    chk("pre_rst_open", {24'd0, bank_open}, 32'h08);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_busy_valid", {31'd0, out_valid}, 0);
    chk("rst_busy_open", {24'd0, bank_open}, 0);
    chk("rst_busy_ready", {31'd0, in_ready}, 1);
    chk("rst_busy_cmd", {28'd0, out_cmd}, 0);
    $display("[TB] reset busy: out_valid=%0d bank_open=%0h", out_valid, bank_open);
    sys_rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int r;
      bit v, cs, ordy;
      r    = ($urandom_range(0, 1) != 0) ? 32'h1111 : 32'h2222;
      a    = (r << 16) | ($urandom_range(0, 1023) << 6) |
             ($urandom_range(0, 7) << 3) | $urandom_range(0, 7);
      v    = ($urandom_range(0, 9) < 8);
      cs   = ($urandom_range(0, 9) < 9);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, cs, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, a, ordy);
      $display("[TB] rnd %0d: addr=%08h v=%0d ordy=%0d -> valid=%0d cmd=%0d err=%0d open=%0h",
               n, a, v, ordy, out_valid, out_cmd, out_err, bank_open);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
